// File: rtl/adc_frame_packer_pkg.sv
// adc_pack_pkg: shared types, default sizes and the enabled-channel search helper
package adc_pack_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

    localparam int ADC_QTD_DEF = 8;
    localparam int NCH         = 2 * ADC_QTD_DEF;
    localparam int CH_W        = $clog2(NCH);
    localparam int MAX_NCH     = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } next_t;

    // Lowest set bit of en at or above start; found=0 when none exists.
    function automatic next_t next_enabled(input logic [MAX_NCH-1:0] en, input logic [5:0] start);
        next_t r;
        r = '0;
        for (int i = MAX_NCH - 1; i >= 0; i--)
            if (en[i] && 6'(i) >= start) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        return r;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// adc_frame_packer_if: AXI-Stream bundle carrying tagged samples
interface adc_frame_packer_if #(
    parameter int TDATA_W = 32,
    parameter int TUSER_W = adc_pack_pkg::CH_W
);
    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: eoc edge detect, per-ADC holding registers and frame completion
module adc_frame_capture #(
    parameter int ADC_QTD  = 8,
    parameter int SAMPLE_W = 32
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [ADC_QTD*SAMPLE_W-1:0] sample_a,
    input  logic [ADC_QTD*SAMPLE_W-1:0] sample_b,
    input  logic [ADC_QTD-1:0]          eoc,
    output logic [ADC_QTD*SAMPLE_W-1:0] hold_a,
    output logic [ADC_QTD*SAMPLE_W-1:0] hold_b,
    output logic                        frame_done
);

    logic [ADC_QTD-1:0]          eoc_q, eoc_rise, pending_q, pending_d;
    logic [ADC_QTD*SAMPLE_W-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;

    assign hold_a = hold_a_q;
    assign hold_b = hold_b_q;

    // Rising edges latch their sample pair (latest wins) and mark the ADC pending;
    // a full pending vector completes the frame and clears all but same-cycle edges.
    always_comb begin
        eoc_rise   = eoc & ~eoc_q;
        frame_done = &pending_q;
        pending_d  = (frame_done ? '0 : pending_q) | eoc_rise;
        hold_a_d   = hold_a_q;
        hold_b_d   = hold_b_q;
        for (int i = 0; i < ADC_QTD; i++) begin
            hold_a_d[i*SAMPLE_W +: SAMPLE_W] = eoc_rise[i] ? sample_a[i*SAMPLE_W +: SAMPLE_W] : hold_a_q[i*SAMPLE_W +: SAMPLE_W];
            hold_b_d[i*SAMPLE_W +: SAMPLE_W] = eoc_rise[i] ? sample_b[i*SAMPLE_W +: SAMPLE_W] : hold_b_q[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Capture state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            eoc_q     <= '0;
            pending_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
        end else begin
            eoc_q     <= eoc;
            pending_q <= pending_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
        end
    end

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: collects ADC sample pairs into frames and streams enabled channels over AXIS
module adc_frame_packer
    import adc_pack_pkg::*;
#(
    parameter int ADC_QTD    = NCH / 2,
    parameter int SAMPLE_W   = 32,
    parameter int AXIS_BYTES = 4,
    parameter int DECIM_W    = 16,
    parameter int FCNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [ADC_QTD*SAMPLE_W-1:0] sample_a,
    input  logic [ADC_QTD*SAMPLE_W-1:0] sample_b,
    input  logic [ADC_QTD-1:0]          eoc,
    input  logic [2*ADC_QTD-1:0]        ch_enable,
    input  logic [DECIM_W-1:0]          decim,
    adc_frame_packer_if.master          m_axis,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [FCNT_W-1:0]           frame_count
);

    localparam int NC   = 2 * ADC_QTD;
    localparam int CW   = $clog2(NC);
    localparam int TD_W = 8 * AXIS_BYTES;

    if (SAMPLE_W > TD_W) begin : g_width_check
        $error("SAMPLE_W must not exceed 8*AXIS_BYTES");
    end

    logic [ADC_QTD*SAMPLE_W-1:0] hold_a, hold_b;
    logic                        frame_done;

    adc_frame_capture #(.ADC_QTD(ADC_QTD), .SAMPLE_W(SAMPLE_W)) u_capture (
        .clk        (clk),
        .srst       (srst),
        .sample_a   (sample_a),
        .sample_b   (sample_b),
        .eoc        (eoc),
        .hold_a     (hold_a),
        .hold_b     (hold_b),
        .frame_done (frame_done)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [NC-1:0]         en_q, en_d;
    logic [SAMPLE_W-1:0]   fbuf_q [NC];
    logic [SAMPLE_W-1:0]   fbuf_d [NC];
    logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic                  overflow_q, overflow_d;
    logic                  eligible, accept, hs, last;
    next_t                 first, nxt;

    assign m_axis.tvalid = state_q == SEND;
    assign m_axis.tlast  = state_q == SEND && last;
    assign m_axis.tdata  = TD_W'(fbuf_q[idx_q]);
    assign m_axis.tuser  = idx_q;
    assign overflow      = overflow_q;
    assign frame_count   = fcnt_q;

    // Decimation, frame acceptance into the buffer, beat sequencing and overflow tracking.
    always_comb begin
        eligible   = dcnt_q == decim;
        dcnt_d     = frame_done ? (eligible ? '0 : dcnt_q + 1'b1) : dcnt_q;
        first      = next_enabled(MAX_NCH'(ch_enable), 6'd0);
        nxt        = next_enabled(MAX_NCH'(en_q), 6'(idx_q) + 6'd1);
        last       = !nxt.found;
        hs         = state_q == SEND && m_axis.tready;
        accept     = frame_done && eligible && state_q == IDLE && first.found;
        overflow_d = (frame_done && eligible && state_q == SEND) ? 1'b1 : overflow_clr ? 1'b0 : overflow_q;
        state_d    = state_q;
        idx_d      = idx_q;
        en_d       = en_q;
        fcnt_d     = fcnt_q;
        fbuf_d     = fbuf_q;
        if (accept) begin
            state_d = SEND;
            idx_d   = CW'(first.idx);
            en_d    = ch_enable;
            for (int i = 0; i < ADC_QTD; i++) begin
                fbuf_d[2*i]   = hold_a[i*SAMPLE_W +: SAMPLE_W];
                fbuf_d[2*i+1] = hold_b[i*SAMPLE_W +: SAMPLE_W];
            end
        end
        if (hs) begin
            state_d = last ? IDLE : SEND;
            fcnt_d  = last ? fcnt_q + 1'b1 : fcnt_q;
            idx_d   = last ? idx_q : CW'(nxt.idx);
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            en_q       <= '0;
            dcnt_q     <= '0;
            fcnt_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NC; i++) fbuf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            en_q       <= en_d;
            dcnt_q     <= dcnt_d;
            fcnt_q     <= fcnt_d;
            overflow_q <= overflow_d;
            fbuf_q     <= fbuf_d;
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed and randomized checks against a frame-level reference model
module tb_adc_frame_packer;

    localparam int AQ = 2, SW = 16, AB = 4, DW = 4, FW = 8, NC = 4, CW = 2, TW = 8 * AB;

    typedef struct {
        logic [TW-1:0] d;
        int            u;
        bit            l;
    } beat_t;

    logic                clk = 1'b0;
    logic                srst = 1'b1;
    logic [AQ*SW-1:0]    sample_a = '0, sample_b = '0;
    logic [AQ-1:0]       eoc = '0;
    logic [NC-1:0]       ch_enable = '1;
    logic [DW-1:0]       decim = '0;
    logic                tready = 1'b1, overflow_clr = 1'b0;
    logic                overflow;
    logic [FW-1:0]       frame_count;

    adc_frame_packer_if #(.TDATA_W(TW), .TUSER_W(CW)) axis ();
    assign axis.tready = tready;

    adc_frame_packer #(.ADC_QTD(AQ), .SAMPLE_W(SW), .AXIS_BYTES(AB), .DECIM_W(DW), .FCNT_W(FW)) dut (
        .clk          (clk),
        .srst         (srst),
        .sample_a     (sample_a),
        .sample_b     (sample_b),
        .eoc          (eoc),
        .ch_enable    (ch_enable),
        .decim        (decim),
        .m_axis       (axis),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state: frame-level view of capture, decimation and the outgoing beat queue.
    logic [AQ-1:0]  m_prev = '0, m_pend = '0;
    logic [SW-1:0]  m_held [NC];
    int             m_dcnt = 0, m_fcnt = 0;
    bit             m_ovf = 0;
    beat_t          m_q[$];
    beat_t          lg[$];
    logic           p_valid = 1'b0;
    beat_t          p_beat;

    initial for (int i = 0; i < NC; i++) m_held[i] = '0;

    always begin : model
        logic [AQ-1:0] rise;
        bit            done, hs, ovf_set;
        int            n;
        @(posedge clk);
        #1;
        if (srst) begin
            m_prev = '0;
            m_pend = '0;
            m_dcnt = 0;
            m_fcnt = 0;
            m_ovf  = 0;
            m_q.delete();
            for (int i = 0; i < NC; i++) m_held[i] = '0;
        end else begin
            if (p_valid && tready) lg.push_back(p_beat);
            rise    = eoc & ~m_prev;
            hs      = m_q.size() != 0 && tready;
            done    = m_pend == '1;
            ovf_set = 0;
            if (hs) begin
                if (m_q[0].l) m_fcnt = (m_fcnt + 1) % (1 << FW);
                m_q.pop_front();
            end
            if (done) begin
                if (m_dcnt == int'(decim)) begin
                    m_dcnt = 0;
                    if (m_q.size() != 0 || hs) ovf_set = 1;
                    else begin
                        n = 0;
                        for (int c = 0; c < NC; c++)
                            if (ch_enable[c]) begin
                                m_q.push_back('{d: TW'(m_held[c]), u: c, l: 0});
                                n++;
                            end
                        if (n != 0) m_q[n-1].l = 1;
                    end
                end else m_dcnt = (m_dcnt + 1) % (1 << DW);
            end
            m_ovf  = ovf_set ? 1 : overflow_clr ? 0 : m_ovf;
            m_pend = (done ? '0 : m_pend) | rise;
            for (int i = 0; i < AQ; i++)
                if (rise[i]) begin
                    m_held[2*i]   = sample_a[i*SW +: SW];
                    m_held[2*i+1] = sample_b[i*SW +: SW];
                end
            m_prev = eoc;
        end
        chk("tvalid", 64'(axis.tvalid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("tdata", 64'(axis.tdata), 64'(m_q[0].d));
            chk("tuser", 64'(axis.tuser), 64'(m_q[0].u));
            chk("tlast", 64'(axis.tlast), 64'(m_q[0].l));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("frame_count", 64'(frame_count), 64'(m_fcnt));
        p_valid = axis.tvalid;
        p_beat  = '{d: axis.tdata, u: int'(axis.tuser), l: axis.tlast};
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] a0, b0, a1, b1);
        sample_a = {a1, a0};
        sample_b = {b1, b0};
        eoc[0] = 1'b1;
        cyc();
        eoc[1] = 1'b1;
        cyc();
        eoc = '0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc(3);
        chk("rst_tvalid", 64'(axis.tvalid), 0);
        chk("rst_tlast", 64'(axis.tlast), 0);
        chk("rst_tdata", 64'(axis.tdata), 0);
        chk("rst_overflow", 64'(overflow), 0);
        srst = 1'b0;
        cyc();
        // All channels, no decimation
        lg.delete();
        send_frame(16'h11, 16'h22, 16'h33, 16'h44);
        cyc(6);
        chk("t1_beats", 64'(lg.size()), 4);
        for (int i = 0; i < 4 && i < lg.size(); i++) begin
            chk("t1_data", 64'(lg[i].d), 64'(16'h11 * (i + 1)));
            chk("t1_user", 64'(lg[i].u), 64'(i));
            chk("t1_last", 64'(lg[i].l), 64'(i == 3));
        end
        chk("t1_fcnt", 64'(frame_count), 1);
        // Channels 1 and 3 only
        ch_enable = 4'b1010;
        lg.delete();
        send_frame(16'h11, 16'h22, 16'h33, 16'h44);
        cyc(6);
        chk("t2_beats", 64'(lg.size()), 2);
        if (lg.size() == 2) begin
            chk("t2_b0", 64'({lg[0].d, 8'(lg[0].u), 7'd0, lg[0].l}), {32'h22, 8'd1, 8'd0});
            chk("t2_b1", 64'({lg[1].d, 8'(lg[1].u), 7'd0, lg[1].l}), {32'h44, 8'd3, 8'd1});
        end
        // Decimation by 3
        ch_enable = '1;
        decim = 4'd2;
        lg.delete();
        for (int k = 1; k <= 6; k++) send_frame(16'h0100 + 16'(k), 16'h0200, 16'h0300, 16'h0400);
        cyc(6);
        chk("t3_beats", 64'(lg.size()), 8);
        if (lg.size() == 8) begin
            chk("t3_f3", 64'(lg[0].d), 64'h103);
            chk("t3_f6", 64'(lg[4].d), 64'h106);
        end
        chk("t3_fcnt", 64'(frame_count), 4);
        decim = '0;
        // Stall while the next frame completes
        tready = 1'b0;
        lg.delete();
        send_frame(16'hA1, 16'hA2, 16'hA3, 16'hA4);
        cyc(2);
        chk("t4_stall_data", 64'(axis.tdata), 64'hA1);
        send_frame(16'hB1, 16'hB2, 16'hB3, 16'hB4);
        chk("t4_overflow", 64'(overflow), 1);
        chk("t4_stall_user", 64'(axis.tuser), 0);
        chk("t4_stall_data2", 64'(axis.tdata), 64'hA1);
        tready = 1'b1;
        cyc(6);
        chk("t4_beats", 64'(lg.size()), 4);
        for (int i = 0; i < 4 && i < lg.size(); i++) chk("t4_data", 64'(lg[i].d), 64'(16'hA1 + i));
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        chk("t4_clr", 64'(overflow), 0);
        // Reset in the middle of a frame
        tready = 1'b0;
        send_frame(16'h51, 16'h52, 16'h53, 16'h54);
        tready = 1'b1;
        cyc();
        tready = 1'b0;
        cyc();
        chk("t5_user", 64'(axis.tuser), 1);
        srst = 1'b1;
        cyc();
        chk("t5_tvalid", 64'(axis.tvalid), 0);
        chk("t5_fcnt", 64'(frame_count), 0);
        srst = 1'b0;
        tready = 1'b1;
        lg.delete();
        send_frame(16'h61, 16'h62, 16'h63, 16'h64);
        cyc(6);
        chk("t5_beats", 64'(lg.size()), 4);
        if (lg.size() != 0) chk("t5_first", 64'({lg[0].d, 8'(lg[0].u)}), {32'h61, 8'd0});
        // All channels disabled
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        ch_enable = '0;
        lg.delete();
        repeat (3) send_frame(16'h71, 16'h72, 16'h73, 16'h74);
        cyc(4);
        chk("t6_beats", 64'(lg.size()), 0);
        chk("t6_fcnt", 64'(frame_count), 0);
        chk("t6_overflow", 64'(overflow), 0);
        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            eoc = AQ'($urandom);
            sample_a = AQ*SW'($urandom);
            sample_b = AQ*SW'($urandom);
            tready = $urandom_range(0, 3) != 0;
            overflow_clr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 31) == 0) ch_enable = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
            if ($urandom_range(0, 63) == 0) decim = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) srst = 1'b1;
            else srst = 1'b0;
            cyc();
        end
        srst = 1'b0;
        eoc = '0;
        overflow_clr = 1'b0;
        tready = 1'b1;
        cyc(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
